// File: rtl/sdspi_writer_pkg.sv
// -----------------------------------------------------------------------------
// sdspi_writer_pkg
// Shared definitions for the SD SPI sector writer and its bus sequencer.
//   - SD SPI controller address map macros (the define.vh set: device base,
//     block buffer base, sector size, write-command register).
//   - Field widths used by the writer datapath.
//   - pack_status(): builds the 32-bit writer status word.
//   - byte_word():   zero-extends a data byte onto the 32-bit bus.
// No ports (package).
// -----------------------------------------------------------------------------
`ifndef SDSPI_DEFINE_VH
`define SDSPI_DEFINE_VH
`define SDSPI_DEVADDR   16'h1000
`define SDSPI_BLOCKADDR 16'h1200
`define SDSPI_BLOCKSIZE 512
`define SDSPI_WRADDR    16'h1010
`endif

package sdspi_writer_pkg;

  localparam int unsigned BUS_ADDR_W = 16;
  localparam int unsigned BUS_DATA_W = 32;
  localparam int unsigned SECTOR_W   = 32;
  localparam int unsigned TC_W       = 12;
  localparam int unsigned ADDR_W     = 10;
  localparam int unsigned STATE_W    = 4;

  // Status word layout: low half of the sector, transfer count, FSM state.
  function automatic logic [31:0] pack_status(
    input logic [15:0]        sector_lo,
    input logic [TC_W-1:0]    tc,
    input logic [STATE_W-1:0] state
  );
    return {sector_lo, tc, state};
  endfunction

  // Data bytes travel in the low lane of the 32-bit write bus.
  function automatic logic [BUS_DATA_W-1:0] byte_word(input logic [7:0] b);
    return {24'h000000, b};
  endfunction

endpackage

// File: rtl/sdspi_writer_apb_master.sv
// -----------------------------------------------------------------------------
// sdspi_apb_master
// Single-transaction APB-style write sequencer, shared by the sector reader
// and writer. A one-cycle i_start launches a write; select, enable and write
// strobes rise together and stay up until the slave answers with pready.
// Ports:
//   clk, rstn             clock, synchronous active-low reset
//   i_start               launch a write (ignored while one is in flight)
//   i_addr, i_wdata       address / data captured at launch
//   i_pready, i_pslverr   slave handshake and error
//   o_psel, o_penable,
//   o_pwrite              bus strobes (always identical)
//   o_paddr, o_pwdata     bus address / data (zero when idle)
//   o_done                transaction completes this cycle
//   o_err                 completing transaction carries pslverr
// -----------------------------------------------------------------------------
module sdspi_apb_master
  import sdspi_writer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_start,
  input  logic [BUS_ADDR_W-1:0] i_addr,
  input  logic [BUS_DATA_W-1:0] i_wdata,
  input  logic                  i_pready,
  input  logic                  i_pslverr,
  output logic                  o_psel,
  output logic                  o_penable,
  output logic                  o_pwrite,
  output logic [BUS_ADDR_W-1:0] o_paddr,
  output logic [BUS_DATA_W-1:0] o_pwdata,
  output logic                  o_done,
  output logic                  o_err
);

  logic                  r_active;
  logic [BUS_ADDR_W-1:0] r_paddr;
  logic [BUS_DATA_W-1:0] r_pwdata;
  logic                  w_done;

  assign w_done = r_active & i_pready;

  // Transaction register: launch on start, release on pready.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_active <= 1'b0;
      r_paddr  <= 16'h0000;
      r_pwdata <= 32'h0000_0000;
    end else if (w_done) begin
      r_active <= 1'b0;
      r_paddr  <= 16'h0000;
      r_pwdata <= 32'h0000_0000;
    end else if (i_start && !r_active) begin
      r_active <= 1'b1;
      r_paddr  <= i_addr;
      r_pwdata <= i_wdata;
    end else begin
      r_active <= r_active;
      r_paddr  <= r_paddr;
      r_pwdata <= r_pwdata;
    end
  end

  // One flop drives all three strobes so they can never disagree.
  assign o_psel    = r_active;
  assign o_penable = r_active;
  assign o_pwrite  = r_active;
  assign o_paddr   = r_paddr;
  assign o_pwdata  = r_pwdata;
  assign o_done    = w_done;
  assign o_err     = w_done & i_pslverr;

endmodule

// File: rtl/sdspi_writer.sv
// -----------------------------------------------------------------------------
// sdspi_writer
// Writes one sector to the SD SPI controller: fetches BLOCKSIZE bytes from a
// byte source, pushes each into the controller block buffer over the APB-style
// bus, issues the write command with the sector number, then waits for the
// card to go busy and come back idle.
// Ports:
//   clk, rstn                     clock, synchronous active-low reset
//   wstart, wsector               level request / target sector
//   wbusy, wdone, werr            transfer status
//   inreq, inaddr, inen, inbyte   byte source handshake
//   psel..pwdata, prdata,
//   pready, pslverr               bus master to the controller
//   sdsbusy, sdspi_status         controller busy / state ([15:8] ctrl, [7:0] sd)
//   w_writer_status               {sector[15:0], tc[11:0], state[3:0]}
// -----------------------------------------------------------------------------
module sdspi_writer
  import sdspi_writer_pkg::*;
#(
  parameter int BLOCKSIZE = `SDSPI_BLOCKSIZE
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        wstart,
  input  logic [31:0] wsector,
  output logic        wbusy,
  output logic        wdone,
  output logic        werr,
  output logic        inreq,
  output logic [8:0]  inaddr,
  input  logic        inen,
  input  logic [7:0]  inbyte,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [15:0] paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr,
  input  logic        sdsbusy,
  input  logic [31:0] sdspi_status,
  output logic [31:0] w_writer_status
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_REQ    = 4'd1;
  localparam logic [3:0] S_BWR    = 4'd2;
  localparam logic [3:0] S_BWAIT  = 4'd3;
  localparam logic [3:0] S_NEXT   = 4'd4;
  localparam logic [3:0] S_CMD    = 4'd5;
  localparam logic [3:0] S_CWAIT  = 4'd6;
  localparam logic [3:0] S_SDBUSY = 4'd7;
  localparam logic [3:0] S_SDIDLE = 4'd8;
  localparam logic [3:0] S_DONE   = 4'd9;

  localparam logic [ADDR_W-1:0] LP_BLOCKSIZE = 10'(BLOCKSIZE);

  logic [STATE_W-1:0]    r_state;
  logic [ADDR_W-1:0]     r_addr;
  logic [SECTOR_W-1:0]   r_sector;
  logic [TC_W-1:0]       r_tc;
  logic                  r_werr;
  logic                  r_wbusy;
  logic                  r_wdone;
  logic                  r_inreq;
  logic [7:0]            r_byte;

  logic [STATE_W-1:0]    w_state_nxt;
  logic [ADDR_W-1:0]     w_addr_nxt;
  logic [SECTOR_W-1:0]   w_sector_nxt;
  logic [TC_W-1:0]       w_tc_nxt;
  logic                  w_werr_nxt;
  logic                  w_wbusy_nxt;
  logic                  w_wdone_nxt;
  logic                  w_inreq_nxt;
  logic [7:0]            w_byte_nxt;
  logic                  w_bus_start;
  logic [BUS_ADDR_W-1:0] w_bus_addr;
  logic [BUS_DATA_W-1:0] w_bus_wdata;
  logic                  w_bus_done;
  logic                  w_bus_err;

  logic [7:0]            w_sdctrl;
  logic [7:0]            w_sdstate;
  logic                  w_sd_quiet;
  logic                  w_accept;
  logic [ADDR_W-1:0]     w_addr_inc;
  logic                  w_unused;

  assign w_sdctrl   = sdspi_status[15:8];
  assign w_sdstate  = sdspi_status[7:0];
  assign w_sd_quiet = !sdsbusy && (w_sdstate == 8'h00) && (w_sdctrl == 8'h00);
  assign w_accept   = wstart && w_sd_quiet && !pready && !r_wdone;
  // 10-bit counter: 511 + 1 reaches 512 instead of wrapping to 0.
  assign w_addr_inc = r_addr + 10'd1;
  assign w_unused   = ^{prdata, sdspi_status[31:16]};

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_REQ;
        else          w_state_nxt = S_IDLE;
      end
      S_REQ: begin
        if (inen) w_state_nxt = S_BWR;
        else      w_state_nxt = S_REQ;
      end
      S_BWR: begin
        if (!pready && (w_sdctrl == 8'h00)) w_state_nxt = S_BWAIT;
        else                                w_state_nxt = S_BWR;
      end
      S_BWAIT: begin
        if (w_bus_done) w_state_nxt = S_NEXT;
        else            w_state_nxt = S_BWAIT;
      end
      S_NEXT: begin
        if (w_addr_inc == LP_BLOCKSIZE) w_state_nxt = S_CMD;
        else                            w_state_nxt = S_REQ;
      end
      S_CMD: begin
        if (!pready) w_state_nxt = S_CWAIT;
        else         w_state_nxt = S_CMD;
      end
      S_CWAIT: begin
        // Any error so far (bytes or command) skips the card-busy wait.
        if (w_bus_done) begin
          if (r_werr || w_bus_err) w_state_nxt = S_DONE;
          else                     w_state_nxt = S_SDBUSY;
        end else begin
          w_state_nxt = S_CWAIT;
        end
      end
      S_SDBUSY: begin
        if (sdsbusy && (w_sdstate != 8'h00)) w_state_nxt = S_SDIDLE;
        else                                 w_state_nxt = S_SDBUSY;
      end
      S_SDIDLE: begin
        if (w_sd_quiet) w_state_nxt = S_DONE;
        else            w_state_nxt = S_SDIDLE;
      end
      S_DONE: begin
        if (!wstart) w_state_nxt = S_IDLE;
        else         w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of datapath/output registers and bus launch requests.
  always_comb begin
    w_addr_nxt   = r_addr;
    w_sector_nxt = r_sector;
    w_tc_nxt     = r_tc;
    w_werr_nxt   = r_werr;
    w_wbusy_nxt  = r_wbusy;
    w_wdone_nxt  = r_wdone;
    w_inreq_nxt  = r_inreq;
    w_byte_nxt   = r_byte;
    w_bus_start  = 1'b0;
    w_bus_addr   = 16'h0000;
    w_bus_wdata  = 32'h0000_0000;
    case (r_state)
      S_IDLE: begin
        if (w_state_nxt == S_REQ) begin
          w_addr_nxt   = 10'd0;
          w_sector_nxt = wsector;
          w_tc_nxt     = r_tc + 12'd1;
          w_werr_nxt   = 1'b0;
          w_wbusy_nxt  = 1'b1;
          w_inreq_nxt  = 1'b1;
        end else begin
          w_inreq_nxt  = 1'b0;
        end
      end
      S_REQ: begin
        if (inen) begin
          w_byte_nxt  = inbyte;
          w_inreq_nxt = 1'b0;
        end else begin
          w_inreq_nxt = 1'b1;
        end
      end
      S_BWR: begin
        if (w_state_nxt == S_BWAIT) begin
          w_bus_start = 1'b1;
          w_bus_addr  = `SDSPI_BLOCKADDR + {6'b000000, r_addr};
          w_bus_wdata = byte_word(r_byte);
        end else begin
          w_bus_start = 1'b0;
        end
      end
      S_BWAIT: begin
        // A byte error is only recorded; the sector keeps going.
        if (w_bus_done) w_werr_nxt = r_werr | w_bus_err;
        else            w_werr_nxt = r_werr;
      end
      S_NEXT: begin
        w_addr_nxt = w_addr_inc;
        if (w_state_nxt == S_REQ) w_inreq_nxt = 1'b1;
        else                      w_inreq_nxt = 1'b0;
      end
      S_CMD: begin
        if (w_state_nxt == S_CWAIT) begin
          w_bus_start = 1'b1;
          w_bus_addr  = `SDSPI_WRADDR;
          w_bus_wdata = r_sector;
        end else begin
          w_bus_start = 1'b0;
        end
      end
      S_CWAIT: begin
        if (w_bus_done) w_werr_nxt = r_werr | w_bus_err;
        else            w_werr_nxt = r_werr;
        if (w_state_nxt == S_DONE) begin
          w_wdone_nxt = 1'b1;
          w_wbusy_nxt = 1'b0;
        end else begin
          w_wdone_nxt = r_wdone;
        end
      end
      S_SDBUSY: begin
        w_wdone_nxt = 1'b0;
      end
      S_SDIDLE: begin
        if (w_state_nxt == S_DONE) begin
          w_wdone_nxt = 1'b1;
          w_wbusy_nxt = 1'b0;
        end else begin
          w_wdone_nxt = 1'b0;
        end
      end
      S_DONE: begin
        if (w_state_nxt == S_IDLE) w_wdone_nxt = 1'b0;
        else                       w_wdone_nxt = 1'b1;
      end
      default: begin
        w_inreq_nxt = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_addr   <= 10'd0;
      r_sector <= 32'h0000_0000;
      r_tc     <= 12'd0;
      r_werr   <= 1'b0;
      r_wbusy  <= 1'b0;
      r_wdone  <= 1'b0;
      r_inreq  <= 1'b0;
      r_byte   <= 8'h00;
    end else begin
      r_addr   <= w_addr_nxt;
      r_sector <= w_sector_nxt;
      r_tc     <= w_tc_nxt;
      r_werr   <= w_werr_nxt;
      r_wbusy  <= w_wbusy_nxt;
      r_wdone  <= w_wdone_nxt;
      r_inreq  <= w_inreq_nxt;
      r_byte   <= w_byte_nxt;
    end
  end

  sdspi_apb_master u_apb (
    .clk       (clk),
    .rstn      (rstn),
    .i_start   (w_bus_start),
    .i_addr    (w_bus_addr),
    .i_wdata   (w_bus_wdata),
    .i_pready  (pready),
    .i_pslverr (pslverr),
    .o_psel    (psel),
    .o_penable (penable),
    .o_pwrite  (pwrite),
    .o_paddr   (paddr),
    .o_pwdata  (pwdata),
    .o_done    (w_bus_done),
    .o_err     (w_bus_err)
  );

  assign wbusy           = r_wbusy;
  assign wdone           = r_wdone;
  assign werr            = r_werr;
  assign inreq           = r_inreq;
  assign inaddr          = r_addr[8:0];
  assign w_writer_status = pack_status(r_sector[15:0], r_tc, r_state);

endmodule

// File: tb/tb_sdspi_writer.sv
// Directed bench for sdspi_writer: byte source, 2-cycle bus responder and a
// small SD controller busy model run alongside one linear stimulus sequence.
module tb_sdspi_writer;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        wstart = 1'b0;
  logic [31:0] wsector = 32'h0;
  logic        wbusy, wdone, werr, inreq;
  logic [8:0]  inaddr;
  logic        inen = 1'b0;
  logic [7:0]  inbyte = 8'h00;
  logic        psel, penable, pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata = 32'h0;
  logic        pready = 1'b0;
  logic        pslverr = 1'b0;
  logic        sdsbusy = 1'b0;
  logic [31:0] sdspi_status = 32'h0;
  logic [31:0] w_writer_status;

  int errors = 0;
  int checks = 0;

  // stimulus controls (written by the main sequence only)
  int          gen = 0;
  logic [7:0]  src_xor = 8'h00;
  bit          src_rand = 1'b0;
  bit          err_en = 1'b0;
  logic [15:0] err_addr = 16'h0;

  // source / model private state
  int src_gen = 0, src_idx = 0, src_wait = 0;
  int mdl_gen = 0, bus_cnt = 0, sd_cnt = 0, log_n = 0;
  logic [15:0] log_addr [0:1023];
  logic [31:0] log_data [0:1023];

  sdspi_writer dut (
    .clk(clk), .rstn(rstn), .wstart(wstart), .wsector(wsector),
    .wbusy(wbusy), .wdone(wdone), .werr(werr),
    .inreq(inreq), .inaddr(inaddr), .inen(inen), .inbyte(inbyte),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .sdsbusy(sdsbusy), .sdspi_status(sdspi_status),
    .w_writer_status(w_writer_status)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // byte source: answers inreq with a one-cycle inen after 0..7 cycles
  always @(negedge clk) begin
    if (gen != src_gen) begin
      src_gen = gen; src_idx = 0; src_wait = 0;
    end
    if (inen) begin
      inen = 1'b0;
      check("inreq_drop", 64'(inreq), 64'd0);
    end else if (inreq) begin
      if (src_wait == 0) begin
        check("inaddr_seq", 64'(inaddr), 64'(src_idx));
        inbyte = inaddr[7:0] ^ src_xor;
        inen = 1'b1;
        src_idx++;
        src_wait = src_rand ? int'($urandom_range(7, 0)) : 0;
      end else begin
        src_wait--;
      end
    end
  end

  // bus responder (pready in 2nd select cycle), write log, SD busy model
  always @(negedge clk) begin
    if (gen != mdl_gen) begin
      mdl_gen = gen; log_n = 0;
    end
    if (sd_cnt != 0) begin
      sd_cnt++;
      if (sd_cnt == 3) begin
        sdsbusy = 1'b1; sdspi_status = 32'h0000_0305;
      end else if (sd_cnt == 7) begin
        sdsbusy = 1'b0; sdspi_status = 32'h0; sd_cnt = 0;
      end
    end
    if (pready) begin
      pready = 1'b0; pslverr = 1'b0; bus_cnt = 0;
    end else if (psel) begin
      bus_cnt++;
      if (bus_cnt == 2) begin
        check("bus_strobes", 64'({psel, penable, pwrite}), 64'd7);
        pready = 1'b1;
        pslverr = err_en && (paddr == err_addr);
        if (log_n < 1024) begin
          log_addr[log_n] = paddr; log_data[log_n] = pwdata;
        end
        log_n++;
        if (paddr == `SDSPI_WRADDR && !pslverr) sd_cnt = 1;
      end
    end else begin
      bus_cnt = 0;
    end
  end

  task automatic start_xfer(input string tag, input logic [31:0] sec, input logic [7:0] xr,
                            input bit rnd, input logic [11:0] tc);
    @(negedge clk);
    gen++; src_xor = xr; src_rand = rnd; wsector = sec; wstart = 1'b1;
    @(negedge clk);
    check({tag, "_busy"}, 64'(wbusy), 64'd1);
    check({tag, "_status_req"}, 64'(w_writer_status), 64'({sec[15:0], tc, 4'd1}));
    check({tag, "_inreq0"}, 64'({inreq, inaddr}), 64'({1'b1, 9'd0}));
  endtask

  task automatic check_sector(input string tag, input logic [31:0] sec, input logic [7:0] xr);
    logic [15:0] ea;
    logic [7:0]  eb;
    check({tag, "_nwrites"}, 64'(log_n), 64'd513);
    for (int i = 0; i < 512; i++) begin
      ea = 16'(`SDSPI_BLOCKADDR + i);
      eb = 8'(i) ^ xr;
      check({tag, "_byte"}, 64'({log_addr[i], log_data[i]}), 64'({ea, 24'h0, eb}));
    end
    check({tag, "_cmd"}, 64'({log_addr[512], log_data[512]}), 64'({`SDSPI_WRADDR, sec}));
  endtask

  task automatic finish_xfer(input string tag, input logic [31:0] sec, input logic [7:0] xr,
                             input logic [11:0] tc, input logic ewerr);
    int n;
    n = 0;
    while (wdone !== 1'b1 && n < 20000) begin
      @(negedge clk); n++;
    end
    check({tag, "_wdone"}, 64'(wdone), 64'd1);
    check({tag, "_werr"}, 64'(werr), 64'(ewerr));
    check({tag, "_wbusy_off"}, 64'(wbusy), 64'd0);
    check({tag, "_status_done"}, 64'(w_writer_status), 64'({sec[15:0], tc, 4'd9}));
    check_sector(tag, sec, xr);
    // wstart still high: must stay in DONE with no new transfer
    repeat (10) @(negedge clk);
    check({tag, "_hold_done"}, 64'({wdone, wbusy}), 64'({1'b1, 1'b0}));
    check({tag, "_hold_nwrites"}, 64'(log_n), 64'd513);
    check({tag, "_hold_status"}, 64'(w_writer_status), 64'({sec[15:0], tc, 4'd9}));
    wstart = 1'b0;
    @(negedge clk);
    check({tag, "_release"}, 64'(wdone), 64'd0);
    check({tag, "_status_idle"}, 64'(w_writer_status), 64'({sec[15:0], tc, 4'd0}));
    repeat (12) @(negedge clk);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_status", 64'(w_writer_status), 64'd0);
    check("rst_bus", 64'({psel, penable, pwrite, paddr, pwdata}), 64'd0);
    check("rst_flags", 64'({wbusy, wdone, werr, inreq, inaddr}), 64'd0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // plain sector, incrementing bytes
    start_xfer("t1", 32'h0000_1234, 8'h00, 1'b0, 12'd1);
    finish_xfer("t1", 32'h0000_1234, 8'h00, 12'd1, 1'b0);

    // random source delays, scrambled data
    start_xfer("t2", 32'hCAFE_BEEF, 8'hA5, 1'b1, 12'd2);
    finish_xfer("t2", 32'hCAFE_BEEF, 8'hA5, 12'd2, 1'b0);

    // slave error on byte 100: sector still completes, werr reported
    err_en = 1'b1; err_addr = 16'(`SDSPI_BLOCKADDR + 100);
    start_xfer("t3", 32'h0000_0042, 8'h3C, 1'b0, 12'd3);
    finish_xfer("t3", 32'h0000_0042, 8'h3C, 12'd3, 1'b1);

    // slave error on the command: DONE without any card-busy phase
    err_addr = `SDSPI_WRADDR;
    start_xfer("t4", 32'h0001_0203, 8'h00, 1'b0, 12'd4);
    finish_xfer("t4", 32'h0001_0203, 8'h00, 12'd4, 1'b1);
    err_en = 1'b0;

    // reset in the middle of byte 300, then a fresh transfer from byte 0
    start_xfer("t5", 32'h0000_0077, 8'h00, 1'b0, 12'd5);
    n = 0;
    while (!(inreq === 1'b1 && inaddr === 9'd300) && n < 5000) begin
      @(negedge clk); n++;
    end
    check("t5_reach300", 64'({inreq, inaddr}), 64'({1'b1, 9'd300}));
    rstn = 1'b0; wstart = 1'b0;
    @(negedge clk);
    check("t5_rst_status", 64'(w_writer_status), 64'd0);
    check("t5_rst_bus", 64'({psel, penable, pwrite, paddr, pwdata}), 64'd0);
    check("t5_rst_flags", 64'({wbusy, wdone, werr, inreq, inaddr}), 64'd0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    check("t5_idle_after_rst", 64'({wbusy, inreq, psel}), 64'd0);
    start_xfer("t6", 32'h0000_0077, 8'h00, 1'b0, 12'd1);
    finish_xfer("t6", 32'h0000_0077, 8'h00, 12'd1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
